// File: rtl/dev_dumper_pkg.sv
// Shared types and constants for the RAM-to-UART hex dumper.
// RAM geometry matches the loader/CPU view of the byte RAM.
package dev_dumper_pkg;

  localparam int unsigned RAM_ADDR_W    = 8;
  localparam int unsigned RAM_BYTE_SIZE = 1 << RAM_ADDR_W;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HI,
    ST_LO,
    ST_SEP,
    ST_FIN
  } dumper_state_t;

endpackage

// File: rtl/dev_dumper_if.sv
// Byte RAM read port and character IO port seen by RAM/IO switch clients.
interface if_ram;
  import dev_dumper_pkg::*;

  logic [RAM_ADDR_W-1:0] addr;
  logic                  rd_en;
  logic [7:0]            rd_data;

  modport client (output addr, output rd_en, input rd_data);
  modport server (input addr, input rd_en, output rd_data);
endinterface

interface if_io;
  logic       putc_push;
  logic [7:0] putc_char;
  logic       putc_en;
  logic       getc_pop;

  modport client (output putc_push, output putc_char, output getc_pop, input putc_en);
  modport server (input putc_push, input putc_char, input getc_pop, output putc_en);
endinterface

// File: rtl/dev_dumper_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module dev_hex_ascii (
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii_c
);

  always_comb begin
    if (i_nib < 4'd10) o_ascii_c = 8'h30 + {4'h0, i_nib};
    else               o_ascii_c = 8'h37 + {4'h0, i_nib};
  end

endmodule

// File: rtl/dev_dumper.sv
// Reads len bytes from RAM starting at addr and prints them as hex text,
// BYTES_PER_LINE bytes per line, space separated, every line ends in LF.
module dev_dumper
  import dev_dumper_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter int unsigned LEN_W          = RAM_ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  if_ram.client                 ram,
  if_io.client                  io
);

  localparam int unsigned     COL_W    = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BYTES_PER_LINE - 1);

  dumper_state_t         r_state, w_state_nxt;
  logic [RAM_ADDR_W-1:0] r_cur, r_addr, w_cur_nxt;
  logic [LEN_W-1:0]      r_rem, w_rem_nxt;
  logic [COL_W-1:0]      r_col, w_col_nxt;
  logic [7:0]            r_byte, r_char, w_char_nxt, w_hex;
  logic [3:0]            w_nib;
  logic                  r_busy, r_done, r_rd_en, r_emit;
  logic                  w_last;

  assign w_last = (r_rem == LEN_W'(1));

  // Digit for the next character: high nibble straight off RAM, low nibble from the held byte
  assign w_nib = (r_state == ST_WAIT) ? ram.rd_data[7:4] : r_byte[3:0];

  dev_hex_ascii u_hex (
    .i_nib     (w_nib),
    .o_ascii_c (w_hex)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (len == '0) ? ST_FIN : ST_FETCH;
      ST_FETCH: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_HI;
      ST_HI:    if (io.putc_en) w_state_nxt = ST_LO;
      ST_LO:    if (io.putc_en) w_state_nxt = ST_SEP;
      ST_SEP:   if (io.putc_en) w_state_nxt = w_last ? ST_FIN : ST_FETCH;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the datapath; the character is prepared one state ahead of its push
  always_comb begin
    w_char_nxt = r_char;
    w_cur_nxt  = r_cur;
    w_rem_nxt  = r_rem;
    w_col_nxt  = r_col;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cur_nxt = addr;
          w_rem_nxt = len;
          w_col_nxt = '0;
        end
      end
      ST_WAIT: w_char_nxt = w_hex;
      ST_HI:   if (io.putc_en) w_char_nxt = w_hex;
      ST_LO: begin
        if (io.putc_en) w_char_nxt = (w_last || (r_col == COL_LAST)) ? ASCII_LF : ASCII_SP;
      end
      ST_SEP: begin
        if (io.putc_en) begin
          w_cur_nxt = r_cur + RAM_ADDR_W'(1);
          w_rem_nxt = r_rem - LEN_W'(1);
          w_col_nxt = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_emit  <= 1'b0;
      r_cur   <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_col   <= '0;
      r_byte  <= '0;
      r_char  <= '0;
    end else begin
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_FIN);
      r_rd_en <= (w_state_nxt == ST_FETCH);
      r_emit  <= (w_state_nxt == ST_HI) || (w_state_nxt == ST_LO) || (w_state_nxt == ST_SEP);
      r_cur   <= w_cur_nxt;
      r_rem   <= w_rem_nxt;
      r_col   <= w_col_nxt;
      r_char  <= w_char_nxt;
      if (w_state_nxt == ST_FETCH) r_addr <= w_cur_nxt;
      if (r_state == ST_WAIT)      r_byte <= ram.rd_data;
    end
  end

  // Push is qualified by putc_en in the same cycle so a stalled buffer never sees a push
  assign io.putc_push = r_emit & io.putc_en;
  assign io.putc_char = r_char;
  assign io.getc_pop  = 1'b0;
  assign ram.addr     = r_addr;
  assign ram.rd_en    = r_rd_en;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: doc/dev_dumper.md
# dev_dumper

Sequential RAM-to-UART hex dumper, the transmit-side counterpart of `dev_loader`. On a `start` pulse it reads `len` bytes from RAM beginning at `addr` and emits them over the `if_io` putc path as uppercase ASCII hex text. It sits beside the loader and CPU behind the RAM and IO switches and uses the same `if_ram`/`if_io` client modports, so images can be read back after loading or after the CPU halts.

## Interface

- `BYTES_PER_LINE`, default 16: bytes per output line; must be ≥1.
- `LEN_W`, default `pkg_ram::RAM_ADDR_W + 1`: width of `len`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `addr`  in  `pkg_ram::RAM_ADDR_W`  first byte address; latched on accepted `start`.
- `len`  in  `LEN_W`  byte count; latched on accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the dump completes.
- `ram`  `if_ram.client`  byte read port: address and read request out; data valid exactly one cycle after the request.
- `io`  `if_io.client`  putc path only: drives `putc_push`/`putc_char`, observes `putc_en` (output buffer can accept). `getc_pop` is tied 0.

## Operation

- States: IDLE, FETCH, WAIT, HI, LO, SEP, FIN.
- IDLE: when `start`=1, latch `addr`→cur, `len`→remaining, clear column counter. If `len`=0, go to FIN; otherwise go to FETCH.
- FETCH: assert RAM read of cur for one cycle, then go to WAIT.
- WAIT: capture the RAM data into the byte register, then go to HI.
- HI: when `putc_en`=1, push the hex digit of byte[7:4], then go to LO. Otherwise hold.
- LO: when `putc_en`=1, push the digit of byte[3:0], then go to SEP.
- Digit encoding: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- SEP, when `putc_en`=1:
  - Push 0x0A if remaining=1 or column=BYTES_PER_LINE-1; otherwise push 0x20.
  - Then decrement remaining, increment cur (mod 2^RAM_ADDR_W, wraps to 0), and advance column (mod BYTES_PER_LINE).
  - Next state: FIN if remaining was 1, else FETCH.
- FIN: pulse `done`, then return to IDLE.
- `start` outside IDLE is ignored.
- The output for N bytes is always 3·N characters, and the last character is always 0x0A.

## Timing

- Reset values: `busy`=0, `done`=0, `putc_push`=0, `putc_char`=0, RAM read request=0; state is IDLE.
- `rst` mid-dump aborts on that edge. No further pushes occur and there is no `done`. The push in flight, if any, completes only if it was asserted in the same cycle.
- `putc_push` is a one-cycle pulse. It is asserted only in a cycle where `putc_en`=1, and `putc_char` is valid in that same cycle.
- Throughput with `putc_en` held high is 5 cycles per byte: FETCH, WAIT, HI, LO, SEP.
- First push (high nibble of byte 0) occurs 3 cycles after the `start` edge.
- With `putc_en` held high, `done` asserts 5·N+1 cycles after the `start` edge.
- `len`=0: `done` asserts 1 cycle after `start`, with no pushes and no RAM reads.
- `putc_en` low stalls only HI/LO/SEP. The captured byte is held, and RAM is not re-read.
- RAM address changes only in FETCH.

## Structure

- Add `RAM_ADDR_W` to `pkg_ram` if absent; `RAM_BYTE_SIZE` is already there.
- Put the state enum `dumper_state_t` in a new `pkg_dumper`.
- Nibble-to-ASCII conversion lives in the sub-module `dev_hex_ascii`: a combinational 4→8 bit converter, shared with a future hex loader.
- Top-level integration: add a third client to `dev_ram_switch`/`dev_io_switch`, selected after `cpu_halted`.

## Test plan

- RAM[0x10..0x12]=0x00,0xAB,0x7F; `start` with addr=0x10, len=3, `putc_en`=1 → chars "00 AB 7F\n"; `done` 16 cycles after `start`.
- len=0 → `done` 1 cycle after `start`; zero pushes; `busy` is high for exactly 1 cycle.
- BYTES_PER_LINE=4, len=6, RAM=0x01..0x06 → "01 02 03 04\n05 06\n" (18 chars).
- addr=top address, len=2, RAM[top]=0xFE, RAM[0]=0x12 → "FE 12\n"; the second read is at address 0.
- Random `putc_en` with 50% duty, len=8 → same character stream as with `putc_en`=1; no push while `putc_en`=0; RAM reads count exactly 8.
- Assert `rst` after 2 pushes of a len=4 dump → no push afterwards, no `done`, `busy`=0. A new `start` with len=1 → exactly 3 chars, then `done`.
